// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

  // Mult/div sequencer state encoding
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Default mult/div latencies (busy cycles after the start edge)
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_ctr.sv
// Mult/div busy sequencer: loads a latency on start, counts it down,
// pulses md_done for one cycle after the last busy cycle.
module md_busy_ctr
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy,
  output logic md_done
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e     state, state_nx;
  logic [CW-1:0] md_cnt, cnt_nx;
  logic          done_nx;

  // State, remaining-cycle count and done pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nx;
      md_cnt  <= cnt_nx;
      md_done <= done_nx;
    end
  end

  // Next state: a start while BUSY cannot happen (ID is stalled), so it is ignored
  always_comb begin
    state_nx = state;
    cnt_nx   = md_cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (md_start) begin
          state_nx = BUSY;
          cnt_nx   = md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      BUSY: begin
        cnt_nx = md_cnt - CW'(1);
        if (md_cnt == CW'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign md_busy = (state == BUSY);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: load-use, branch-operand and mult/div
// hazards freeze PC and IF/ID and inject a bubble into ID/EX.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_use_rs0,
  input  logic             id_use_rt0,
  input  logic             id_md_use,
  input  logic [4:0]       ex_wr_addr,
  input  logic             ex_is_load,
  input  logic             ex_writes,
  input  logic [4:0]       mem_wr_addr,
  input  logic             mem_is_load,
  input  logic             ex_md_start,
  input  logic             ex_md_div,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_clr,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic rs_nz, rt_nz;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic stall_lu, stall_br, stall_md, stall;

  md_busy_ctr #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .md_start (ex_md_start),
    .md_div   (ex_md_div),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  // $zero is never a real dependency, so a nonzero source gates every match
  always_comb begin
    rs_nz    = (id_rs != 5'd0);
    rt_nz    = (id_rt != 5'd0);
    rs_ex    = rs_nz & (id_rs == ex_wr_addr);
    rt_ex    = rt_nz & (id_rt == ex_wr_addr);
    rs_mem   = rs_nz & (id_rs == mem_wr_addr);
    rt_mem   = rt_nz & (id_rt == mem_wr_addr);
    stall_lu = ex_is_load & ((id_use_rs & rs_ex) | (id_use_rt & rt_ex));
    stall_br = (ex_writes   & ((id_use_rs0 & rs_ex)  | (id_use_rt0 & rt_ex)))
             | (mem_is_load & ((id_use_rs0 & rs_mem) | (id_use_rt0 & rt_mem)));
    stall_md = id_md_use & (md_busy | ex_md_start);
    stall    = stall_lu | stall_br | stall_md;
    pc_en    = ~stall;
    ifid_en  = ~stall;
    idex_clr = stall;
  end

  // Stalled-cycle performance counter, sticks at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares. A second 4-bit-counter instance
// exercises counter saturation.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_wr_addr, mem_wr_addr;
  logic       id_use_rs, id_use_rt, id_use_rs0, id_use_rt0, id_md_use;
  logic       ex_is_load, ex_writes, mem_is_load, ex_md_start, ex_md_div;
  logic       pc_en, ifid_en, idex_clr, md_busy, md_done;
  logic [31:0] stall_cnt;
  logic       pc_en4, ifid_en4, idex_clr4, md_busy4, md_done4;
  logic [3:0] stall_cnt4;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_rs0(id_use_rs0),
    .id_use_rt0(id_use_rt0), .id_md_use(id_md_use), .ex_wr_addr(ex_wr_addr),
    .ex_is_load(ex_is_load), .ex_writes(ex_writes), .mem_wr_addr(mem_wr_addr),
    .mem_is_load(mem_is_load), .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_clr(idex_clr), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt)
  );

  pipe_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_rs0(id_use_rs0),
    .id_use_rt0(id_use_rt0), .id_md_use(id_md_use), .ex_wr_addr(ex_wr_addr),
    .ex_is_load(ex_is_load), .ex_writes(ex_writes), .mem_wr_addr(mem_wr_addr),
    .mem_is_load(mem_is_load), .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_clr(idex_clr4), .md_busy(md_busy4),
    .md_done(md_done4), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic [4:0] rs, rt, exa, mema;
    logic use_rs, use_rt, use_rs0, use_rt0, md_use;
    logic ex_load, ex_wr, mem_load, start, div;
  } in_t;

  typedef struct {
    logic       pc_en, ifid_en, idex_clr, md_busy, md_done;
    logic [31:0] scnt;
    logic [3:0]  scnt4;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: cycles of busy left, pending done pulse, stall tallies
  int          m_busy = 0;
  bit          m_done = 1'b0;
  int unsigned m_scnt = 0;
  int unsigned m_scnt4 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t nop();
    in_t v;
    v.rs = 0; v.rt = 0; v.exa = 0; v.mema = 0;
    v.use_rs = 0; v.use_rt = 0; v.use_rs0 = 0; v.use_rt0 = 0; v.md_use = 0;
    v.ex_load = 0; v.ex_wr = 0; v.mem_load = 0; v.start = 0; v.div = 0;
    return v;
  endfunction

  // Does ID read a nonzero register that the given producer writes?
  function automatic bit dep(input logic [4:0] r, input bit used, input logic [4:0] dst);
    return used && (r != 0) && (r == dst);
  endfunction

  task automatic apply(input in_t v);
    id_rs = v.rs; id_rt = v.rt; ex_wr_addr = v.exa; mem_wr_addr = v.mema;
    id_use_rs = v.use_rs; id_use_rt = v.use_rt; id_use_rs0 = v.use_rs0;
    id_use_rt0 = v.use_rt0; id_md_use = v.md_use; ex_is_load = v.ex_load;
    ex_writes = v.ex_wr; mem_is_load = v.mem_load; ex_md_start = v.start;
    ex_md_div = v.div;
  endtask

  // One clock of stimulus: predict this cycle's outputs, then advance the model
  task automatic step(input in_t v);
    exp_t e;
    bit lu, br, md, st;
    apply(v);
    lu = v.ex_load && (dep(v.rs, v.use_rs, v.exa) || dep(v.rt, v.use_rt, v.exa));
    br = (v.ex_wr && (dep(v.rs, v.use_rs0, v.exa) || dep(v.rt, v.use_rt0, v.exa)))
      || (v.mem_load && (dep(v.rs, v.use_rs0, v.mema) || dep(v.rt, v.use_rt0, v.mema)));
    md = v.md_use && (m_busy > 0 || v.start);
    st = lu || br || md;
    e.pc_en = !st; e.ifid_en = !st; e.idex_clr = st;
    e.md_busy = (m_busy > 0); e.md_done = m_done;
    e.scnt = m_scnt; e.scnt4 = m_scnt4[3:0];
    q.push_back(e);
    @(posedge clk);
    if (st) begin
      m_scnt++;
      if (m_scnt4 < 15) m_scnt4++;
    end
    m_done = (m_busy == 1);
    if (m_busy > 0) m_busy--;
    else if (v.start) m_busy = v.div ? 10 : 5;
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (reset) chk("md_start_while_busy", {31'd0, ex_md_start & md_busy}, 32'd0);
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("pc_en",      {31'd0, pc_en},    {31'd0, me.pc_en});
      chk("ifid_en",    {31'd0, ifid_en},  {31'd0, me.ifid_en});
      chk("idex_clr",   {31'd0, idex_clr}, {31'd0, me.idex_clr});
      chk("md_busy",    {31'd0, md_busy},  {31'd0, me.md_busy});
      chk("md_done",    {31'd0, md_done},  {31'd0, me.md_done});
      chk("stall_cnt",  stall_cnt,         me.scnt);
      chk("stall_cnt4", {28'd0, stall_cnt4}, {28'd0, me.scnt4});
    end
  end

  initial begin
    in_t v;
    int nb;
    logic [31:0] s0;
    reset = 1'b0;
    apply(nop());
    #1;
    chk("rst_pc_en",     {31'd0, pc_en},    32'd1);
    chk("rst_ifid_en",   {31'd0, ifid_en},  32'd1);
    chk("rst_idex_clr",  {31'd0, idex_clr}, 32'd0);
    chk("rst_md_busy",   {31'd0, md_busy},  32'd0);
    chk("rst_md_done",   {31'd0, md_done},  32'd0);
    chk("rst_stall_cnt", stall_cnt,         32'd0);
    #12 reset = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs, then $zero must not match
    v = nop(); v.ex_load = 1; v.exa = 8; v.use_rs = 1; v.rs = 8; step(v);
    step(nop());
    v.rs = 0; v.exa = 0; step(v);
    v = nop(); v.ex_load = 1; v.exa = 7; v.use_rt = 1; v.rt = 7; step(v);

    // Branch operand vs ALU in EX, then vs load in MEM
    v = nop(); v.ex_wr = 1; v.exa = 9; v.use_rs0 = 1; v.rs = 9; step(v);
    v = nop(); v.mem_load = 1; v.mema = 9; v.use_rs0 = 1; v.rs = 9; step(v);
    v.mem_load = 0; step(v);
    v = nop(); v.mem_load = 1; v.mema = 4; v.use_rt0 = 1; v.rt = 4; step(v);

    // Mult with a dependent md instruction waiting in ID
    s0 = stall_cnt; nb = 0;
    v = nop(); v.start = 1; v.md_use = 1; step(v);
    if (md_busy) nb++;
    v.start = 0;
    for (int i = 0; i < 6; i++) begin step(v); if (md_busy) nb++; end
    chk("mult_busy_cycles", nb, 32'd5);
    chk("mult_stall_cycles", stall_cnt - s0, 32'd6);

    // Div back-to-back: second start on the done cycle
    v = nop(); v.start = 1; v.div = 1; step(v);
    for (int i = 0; i < 10; i++) step(nop());
    step(v);
    for (int i = 0; i < 12; i++) step(nop());

    // Async reset in the middle of a divide
    v = nop(); v.start = 1; v.div = 1; v.md_use = 1; step(v);
    v.start = 0;
    for (int i = 0; i < 4; i++) step(v);
    apply(nop());
    reset = 1'b0;
    #1;
    chk("arst_md_busy",   {31'd0, md_busy}, 32'd0);
    chk("arst_stall_cnt", stall_cnt,        32'd0);
    chk("arst_pc_en",     {31'd0, pc_en},   32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rel_md_busy", {31'd0, md_busy}, 32'd0);
    m_busy = 0; m_done = 0; m_scnt = 0; m_scnt4 = 0;
    @(posedge clk); #1;

    // Counter saturation: 20 stalled cycles
    v = nop(); v.ex_load = 1; v.exa = 3; v.use_rs = 1; v.rs = 3;
    for (int i = 0; i < 20; i++) step(v);
    chk("sat_cnt4",  {28'd0, stall_cnt4}, 32'd15);
    chk("sat_cnt32", stall_cnt,           32'd20);

    // Random traffic with small address space to provoke matches
    for (int i = 0; i < 400; i++) begin
      v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
      v.exa = 5'($urandom_range(0, 3)); v.mema = 5'($urandom_range(0, 3));
      v.use_rs = 1'($urandom); v.use_rt = 1'($urandom);
      v.use_rs0 = ($urandom_range(0, 3) == 0); v.use_rt0 = ($urandom_range(0, 3) == 0);
      v.md_use = ($urandom_range(0, 3) == 0);
      v.ex_load = 1'($urandom); v.ex_wr = 1'($urandom); v.mem_load = 1'($urandom);
      v.start = (m_busy == 0) && ($urandom_range(0, 5) == 0);
      v.div = 1'($urandom);
      step(v);
    end

    step(nop());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
